// File: rtl/simd_vector_unit.sv
// Buffered SIMD lane engine: queues incoming vectors in a circular FIFO and
// applies one broadcast-scalar instruction across every lane of each popped vector.
module simd_vector_unit #(
    parameter  int LANES = 4,
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_data,
    input  logic [LANES*WIDTH-1:0] data,
    output logic                   data_ready,
    input  logic                   valid_instruction,
    input  logic [WIDTH+3:0]       instruction,
    input  logic [CW-1:0]          data_size,
    output logic                   instr_ready,
    output logic                   valid_output,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out,
    output logic                   busy,
    output logic                   error
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, next_state;
    logic [LANES*WIDTH-1:0] mem [DEPTH];
    logic [LANES*WIDTH-1:0] head;
    logic [LANES*WIDTH-1:0] result;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count, remaining;
    logic                   sat_q;
    logic [2:0]             op_q;
    logic [WIDTH-1:0]       imm_q;
    logic                   push, load, accept, reject;

    // ADD/SUB use one extra bit so the carry/borrow decides saturation.
    function automatic logic [WIDTH-1:0] lane_op(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0]       op,
                                                 input logic             sat);
        logic [WIDTH:0] wide;
        wide    = '0;
        lane_op = a;
        case (op)
            3'd0: lane_op = a;
            3'd1: begin
                wide    = {1'b0, a} + {1'b0, b};
                lane_op = (sat && wide[WIDTH]) ? '1 : wide[WIDTH-1:0];
            end
            3'd2: begin
                wide    = {1'b0, a} - {1'b0, b};
                lane_op = (sat && wide[WIDTH]) ? '0 : wide[WIDTH-1:0];
            end
            3'd3: lane_op = a & b;
            3'd4: lane_op = a | b;
            3'd5: lane_op = a ^ b;
            3'd6: lane_op = (a > b) ? a : b;
            3'd7: lane_op = (a < b) ? a : b;
        endcase
    endfunction

    assign data_ready = (count != CW'(DEPTH));
    assign push       = valid_data && data_ready;
    assign load       = (state == RUN) && (remaining != '0) && (!valid_output || out_ready);
    assign accept     = (state == IDLE) && valid_instruction &&
                        (data_size != '0) && (data_size <= count);
    assign reject     = (state == IDLE) && valid_instruction && !accept;
    assign head       = mem[rd_ptr];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign result[i*WIDTH +: WIDTH] = lane_op(head[i*WIDTH +: WIDTH], imm_q, op_q, sat_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // RUN retires once nothing remains and the last result is gone or leaving now.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = RUN;
            RUN:  if ((remaining == '0) && (!valid_output || out_ready)) next_state = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == RUN);
        instr_ready = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining    <= '0;
            valid_output <= 1'b0;
            out          <= '0;
            error        <= 1'b0;
            sat_q        <= 1'b0;
            op_q         <= '0;
            imm_q        <= '0;
        end else begin
            error <= reject;
            if (accept) begin
                sat_q     <= instruction[WIDTH+3];
                op_q      <= instruction[WIDTH+2:WIDTH];
                imm_q     <= instruction[WIDTH-1:0];
                remaining <= data_size;
            end else if (load) begin
                remaining <= remaining - 1'b1;
            end
            if (load) begin
                out          <= result;
                valid_output <= 1'b1;
            end else if (valid_output && out_ready) begin
                valid_output <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_simd_vector_unit.sv
// Directed-vector bench for simd_vector_unit (LANES=4, WIDTH=8, DEPTH=16).
module tb_simd_vector_unit;
    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   valid_data;
    logic [LANES*WIDTH-1:0] data;
    logic                   data_ready;
    logic                   valid_instruction;
    logic [WIDTH+3:0]       instruction;
    logic [CW-1:0]          data_size;
    logic                   instr_ready;
    logic                   valid_output;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out;
    logic                   busy;
    logic                   error;

    int checks = 0;
    int errors = 0;

    simd_vector_unit #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .valid_data(valid_data), .data(data), .data_ready(data_ready),
        .valid_instruction(valid_instruction), .instruction(instruction),
        .data_size(data_size), .instr_ready(instr_ready),
        .valid_output(valid_output), .out_ready(out_ready), .out(out),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [31:0] v);
        valid_data = 1'b1;
        data       = v;
        tick();
        valid_data = 1'b0;
    endtask

    task automatic issue(input logic s, input logic [2:0] op, input logic [7:0] imm, input logic [4:0] n);
        valid_instruction = 1'b1;
        instruction       = {s, op, imm};
        data_size         = n;
        tick();
        valid_instruction = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        checks++; if (valid_output !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_output); end
        checks++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL reset_out: got %h expected 00000000", out); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %b expected 0", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_data_ready: got %b expected 1", data_ready); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_instr_ready: got %b expected 1", instr_ready); end
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
    endtask

    task automatic test_add_wrap();
        out_ready = 1'b1;
        push_vec(32'h04030201);
        push_vec(32'hFF100080);
        issue(1'b0, 3'd1, 8'h01, 5'd2);
        checks++; if (busy !== 1'b1 || instr_ready !== 1'b0 || valid_output !== 1'b0) begin
            errors++; $display("[TB] FAIL add_wrap_run: busy/instr_ready/valid got %b%b%b expected 100", busy, instr_ready, valid_output);
        end
        tick();
        checks++; if (valid_output !== 1'b1 || out !== 32'h05040302) begin
            errors++; $display("[TB] FAIL add_wrap_out0: got v=%b %h expected v=1 05040302", valid_output, out);
        end
        tick();
        checks++; if (valid_output !== 1'b1 || out !== 32'h00110181) begin
            errors++; $display("[TB] FAIL add_wrap_out1: got v=%b %h expected v=1 00110181", valid_output, out);
        end
        tick();
        checks++; if (valid_output !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL add_wrap_idle: valid/busy/instr_ready got %b%b%b expected 001", valid_output, busy, instr_ready);
        end
    endtask

    task automatic test_saturate();
        push_vec(32'h04030201);
        push_vec(32'hFF100080);
        issue(1'b1, 3'd1, 8'hF0, 5'd2);
        tick();
        checks++; if (valid_output !== 1'b1 || out !== 32'hF4F3F2F1) begin
            errors++; $display("[TB] FAIL sat_add0: got v=%b %h expected v=1 F4F3F2F1", valid_output, out);
        end
        tick();
        checks++; if (valid_output !== 1'b1 || out !== 32'hFFFFF0FF) begin
            errors++; $display("[TB] FAIL sat_add1: got v=%b %h expected v=1 FFFFF0FF", valid_output, out);
        end
        tick();
        push_vec(32'h052010FF);
        issue(1'b1, 3'd2, 8'h10, 5'd1);
        tick();
        checks++; if (valid_output !== 1'b1 || out !== 32'h001000EF) begin
            errors++; $display("[TB] FAIL sat_sub: got v=%b %h expected v=1 001000EF", valid_output, out);
        end
        tick();
        checks++; if (busy !== 1'b0 || valid_output !== 1'b0) begin
            errors++; $display("[TB] FAIL sat_idle: busy/valid got %b%b expected 00", busy, valid_output);
        end
    endtask

    task automatic test_ops();
        logic [2:0]  ops  [9] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd1};
        logic        sats [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exps [9] = '{32'hF00FAA55, 32'hB4D36E19, 32'h300C2814, 32'hFC3FBE7D,
                                  32'hCC339669, 32'hF03CAA55, 32'h3C0F3C3C, 32'h2C4BE691,
                                  32'hFF4BE691};
        for (int i = 0; i < 9; i++) begin
            push_vec(32'hF00FAA55);
            issue(sats[i], ops[i], 8'h3C, 5'd1);
            tick();
            checks++; if (valid_output !== 1'b1 || out !== exps[i]) begin
                errors++; $display("[TB] FAIL op_%0d_sat%0d: got v=%b %h expected v=1 %h", ops[i], sats[i], valid_output, out, exps[i]);
            end
            tick();
        end
    endtask

    task automatic test_full_wrap();
        logic [31:0] q[$];
        logic [31:0] exp, nv;
        logic        exp_ready;
        int          n;
        for (int i = 0; i < DEPTH; i++) begin
            nv = 32'hA0000000 + i * 32'h00010101;
            push_vec(nv);
            q.push_back(nv);
        end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b expected 0", data_ready); end
        push_vec(32'hDEADBEEF);
        checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ignore_ready: got %b expected 0", data_ready); end
        issue(1'b0, 3'd0, 8'h00, 5'd16);
        for (int k = 1; k <= DEPTH; k++) begin
            exp_ready = (q.size() != DEPTH);
            checks++; if (data_ready !== exp_ready) begin
                errors++; $display("[TB] FAIL wrap_ready_%0d: got %b expected %b", k, data_ready, exp_ready);
            end
            nv         = 32'hB0000000 + k * 32'h00010101;
            valid_data = 1'b1;
            data       = nv;
            tick();
            exp = q.pop_front();
            if (exp_ready) q.push_back(nv);
            checks++; if (valid_output !== 1'b1 || out !== exp) begin
                errors++; $display("[TB] FAIL wrap_out_%0d: got v=%b %h expected v=1 %h", k, valid_output, out, exp);
            end
        end
        valid_data = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || valid_output !== 1'b0) begin
            errors++; $display("[TB] FAIL wrap_idle: busy/valid got %b%b expected 00", busy, valid_output);
        end
        n = q.size();
        issue(1'b0, 3'd0, 8'h00, 5'(n));
        for (int j = 0; j < n; j++) begin
            tick();
            exp = q.pop_front();
            checks++; if (valid_output !== 1'b1 || out !== exp) begin
                errors++; $display("[TB] FAIL drain_out_%0d: got v=%b %h expected v=1 %h", j, valid_output, out, exp);
            end
        end
        tick();
        checks++; if (busy !== 1'b0 || data_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL drain_idle: busy/data_ready got %b%b expected 01", busy, data_ready);
        end
    endtask

    task automatic test_stall();
        push_vec(32'h1090807F);
        push_vec(32'hFF008180);
        push_vec(32'h01020304);
        out_ready = 1'b0;
        issue(1'b0, 3'd6, 8'h80, 5'd3);
        tick();
        checks++; if (valid_output !== 1'b1 || out !== 32'h80908080) begin
            errors++; $display("[TB] FAIL stall_first: got v=%b %h expected v=1 80908080", valid_output, out);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (valid_output !== 1'b1 || out !== 32'h80908080) begin
                errors++; $display("[TB] FAIL stall_hold_%0d: got v=%b %h expected v=1 80908080", i, valid_output, out);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (valid_output !== 1'b1 || out !== 32'hFF808180) begin
            errors++; $display("[TB] FAIL stall_second: got v=%b %h expected v=1 FF808180", valid_output, out);
        end
        tick();
        checks++; if (valid_output !== 1'b1 || out !== 32'h80808080) begin
            errors++; $display("[TB] FAIL stall_third: got v=%b %h expected v=1 80808080", valid_output, out);
        end
        tick();
        checks++; if (valid_output !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_idle: valid/busy got %b%b expected 00", valid_output, busy);
        end
    endtask

    task automatic test_error();
        push_vec(32'h11223344);
        push_vec(32'h55667788);
        issue(1'b0, 3'd0, 8'h00, 5'd3);
        checks++; if (error !== 1'b1 || instr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL err_too_big: error/instr_ready/busy got %b%b%b expected 110", error, instr_ready, busy);
        end
        tick();
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL err_pulse1: got %b expected 0", error); end
        issue(1'b0, 3'd0, 8'h00, 5'd0);
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL err_zero: error/busy got %b%b expected 10", error, busy);
        end
        tick();
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL err_pulse2: got %b expected 0", error); end
        issue(1'b0, 3'd0, 8'h00, 5'd2);
        valid_instruction = 1'b1;
        instruction       = {1'b1, 3'd1, 8'hFF};
        data_size         = 5'd1;
        checks++; if (busy !== 1'b1 || instr_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL err_run: busy/instr_ready got %b%b expected 10", busy, instr_ready);
        end
        tick();
        checks++; if (valid_output !== 1'b1 || out !== 32'h11223344) begin
            errors++; $display("[TB] FAIL err_keep0: got v=%b %h expected v=1 11223344", valid_output, out);
        end
        tick();
        checks++; if (valid_output !== 1'b1 || out !== 32'h55667788 || error !== 1'b0) begin
            errors++; $display("[TB] FAIL err_keep1: got v=%b e=%b %h expected v=1 e=0 55667788", valid_output, error, out);
        end
        valid_instruction = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || error !== 1'b0) begin
            errors++; $display("[TB] FAIL err_idle: busy/error got %b%b expected 00", busy, error);
        end
        issue(1'b0, 3'd0, 8'h00, 5'd1);
        checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL err_empty: got %b expected 1", error); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        push_vec(32'h01010101);
        push_vec(32'h02020202);
        push_vec(32'h03030303);
        out_ready = 1'b0;
        issue(1'b0, 3'd0, 8'h00, 5'd3);
        tick();
        checks++; if (valid_output !== 1'b1 || out !== 32'h01010101) begin
            errors++; $display("[TB] FAIL midrst_pre: got v=%b %h expected v=1 01010101", valid_output, out);
        end
        reset = 1'b0;
        #1;
        checks++; if (valid_output !== 1'b0 || out !== 32'h0) begin
            errors++; $display("[TB] FAIL midrst_out: got v=%b %h expected v=0 00000000", valid_output, out);
        end
        checks++; if (data_ready !== 1'b1 || busy !== 1'b0 || instr_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL midrst_ctrl: data_ready/busy/instr_ready got %b%b%b expected 101", data_ready, busy, instr_ready);
        end
        #1 reset = 1'b1;
        out_ready = 1'b1;
        tick();
        issue(1'b0, 3'd0, 8'h00, 5'd1);
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_empty: error/busy got %b%b expected 10", error, busy);
        end
        tick();
    endtask

    initial begin
        valid_data        = 1'b0;
        data              = '0;
        valid_instruction = 1'b0;
        instruction       = '0;
        data_size         = '0;
        out_ready         = 1'b1;
        test_reset();
        test_add_wrap();
        test_saturate();
        test_ops();
        test_full_wrap();
        test_stall();
        test_error();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
